// File: rtl/alu.sv
// Two-operand signed ALU with registered result and flags.
// Supported operations are ADD, SUB, AND and XOR. The result and its
// flags are computed combinationally and captured on the rising clock
// edge, so each operation has one cycle of latency and full throughput.
// The asynchronous reset clears the result and forces zero_flag high.
module alu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [1:0]       operation,
  output logic [WIDTH-1:0] result,
  output logic             overflow_flag,
  output logic             zero_flag,
  output logic             sign_flag
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  op_e              op;
  logic             is_sub;
  logic [WIDTH-1:0] addend_b;
  logic [WIDTH-1:0] sum;
  logic             arith_ovf;

  logic [WIDTH-1:0] result_d, result_q;
  logic             overflow_d, overflow_q;
  logic             zero_d, zero_q;
  logic             sign_d, sign_q;

  assign op     = op_e'(operation);
  assign is_sub = (op == OP_SUB);

  // A single adder serves both ADD and SUB.
  // For SUB, B is inverted and the carry-in supplies the +1.
  assign addend_b = is_sub ? ~num2 : num2;
  assign sum      = num1 + addend_b + {{(WIDTH-1){1'b0}}, is_sub};

  // Signed overflow occurs when the adder inputs share a sign and the
  // sum's sign differs from it. Using the effective (possibly inverted) B
  // covers the SUB case: the operands have differing signs and the
  // result's sign differs from num1.
  assign arith_ovf = (num1[WIDTH-1] == addend_b[WIDTH-1]) &&
                     (sum[WIDTH-1]  != num1[WIDTH-1]);

  // Select the result and overflow for the chosen operation, then derive
  // the zero and sign flags from it.
  always_comb begin
    result_d   = '0;
    overflow_d = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB: begin
        result_d   = sum;
        overflow_d = arith_ovf;
      end
      OP_AND: result_d = num1 & num2;
      OP_XOR: result_d = num1 ^ num2;
      default: begin
        result_d   = '0;
        overflow_d = 1'b0;
      end
    endcase
    zero_d = (result_d == '0);
    sign_d = result_d[WIDTH-1];
  end

  // Output register: reset clears it at once, otherwise it captures
  // every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b1;
      sign_q     <= 1'b0;
    end else begin
      result_q   <= result_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      sign_q     <= sign_d;
    end
  end

  assign result        = result_q;
  assign overflow_flag = overflow_q;
  assign zero_flag     = zero_q;
  assign sign_flag     = sign_q;

endmodule

// File: tb/tb_alu.sv
// Testbench for alu. It runs directed vectors with literal expectations,
// then randomized traffic checked every cycle against a behavioural
// model that uses exact wide arithmetic, and finally a mid-stream reset.
module tb_alu;

  localparam int W = 64;

  logic         clk;
  logic         rst;
  logic [W-1:0] num1;
  logic [W-1:0] num2;
  logic [1:0]   operation;
  logic [W-1:0] result;
  logic         overflow_flag;
  logic         zero_flag;
  logic         sign_flag;

  int errors = 0;
  int checks = 0;

  alu #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .num1(num1),
    .num2(num2),
    .operation(operation),
    .result(result),
    .overflow_flag(overflow_flag),
    .zero_flag(zero_flag),
    .sign_flag(sign_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. ADD and SUB are computed exactly in W+1 bits.
  // Overflow means the exact value does not fit in W signed bits.
  logic [W-1:0] exp_result;
  logic         exp_ovf;
  logic         exp_zero;
  logic         exp_sign;
  logic         model_valid = 1'b0;

  task automatic model_eval(input logic [1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, output logic [W-1:0] r,
                            output logic o);
    logic signed [W:0] exact;
    exact = '0;
    o     = 1'b0;
    case (op)
      2'b00: begin
        exact = $signed({a[W-1], a}) + $signed({b[W-1], b});
        r = exact[W-1:0];
        o = (exact > $signed({2'b00, {(W-1){1'b1}}})) ||
            (exact < -$signed({2'b01, {(W-1){1'b0}}}));
      end
      2'b01: begin
        exact = $signed({a[W-1], a}) - $signed({b[W-1], b});
        r = exact[W-1:0];
        o = (exact > $signed({2'b00, {(W-1){1'b1}}})) ||
            (exact < -$signed({2'b01, {(W-1){1'b0}}}));
      end
      2'b10: r = a & b;
      default: r = a ^ b;
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    logic [W-1:0] r;
    logic         o;
    if (rst) begin
      exp_result = '0;
      exp_ovf    = 1'b0;
      exp_zero   = 1'b1;
      exp_sign   = 1'b0;
    end else begin
      model_eval(operation, num1, num2, r, o);
      exp_result = r;
      exp_ovf    = o;
      exp_zero   = (r == '0);
      exp_sign   = r[W-1];
    end
    model_valid = 1'b1;
  end

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the model, taken at the falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("model.result", result, exp_result);
      check("model.overflow", {63'd0, overflow_flag}, {63'd0, exp_ovf});
      check("model.zero", {63'd0, zero_flag}, {63'd0, exp_zero});
      check("model.sign", {63'd0, sign_flag}, {63'd0, exp_sign});
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, ".result"}, result, '0);
    check({tag, ".overflow"}, {63'd0, overflow_flag}, 64'd0);
    check({tag, ".zero"}, {63'd0, zero_flag}, 64'd1);
    check({tag, ".sign"}, {63'd0, sign_flag}, 64'd0);
  endtask

  // Apply one operation at the falling edge. Then check the literal
  // expectation just after the following rising edge.
  task automatic directed(input string name, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] r, input logic o,
                          input logic z, input logic s);
    @(negedge clk);
    operation = op;
    num1      = a;
    num2      = b;
    @(posedge clk);
    #1;
    check({name, ".result"}, result, r);
    check({name, ".overflow"}, {63'd0, overflow_flag}, {63'd0, o});
    check({name, ".zero"}, {63'd0, zero_flag}, {63'd0, z});
    check({name, ".sign"}, {63'd0, sign_flag}, {63'd0, s});
    $display("directed %s: op=%0d a=%h b=%h -> result=%h ovf=%0b z=%0b s=%0b",
             name, op, a, b, result, overflow_flag, zero_flag, sign_flag);
  endtask

  task automatic drive_random();
    operation = 2'($urandom_range(0, 3));
    num1      = {$urandom, $urandom};
    num2      = {$urandom, $urandom};
  endtask

  initial begin
    rst       = 1'b0;
    num1      = '0;
    num2      = '0;
    operation = 2'b00;
    #2 rst = 1'b1;
    #1 check_reset_values("reset_initial");
    repeat (2) @(negedge clk);
    check_reset_values("reset_held");
    #2 rst = 1'b0;

    directed("sub_max_minus_negmax", 2'b01, 64'h7FFF_FFFF_FFFF_FFFF,
             64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1);
    directed("sub_equal", 2'b01, 64'h7FFF_FFFF_FFFF_FFFD,
             64'h7FFF_FFFF_FFFF_FFFD, 64'd0, 1'b0, 1'b1, 1'b0);
    directed("sub_neg_minus_pos", 2'b01, 64'h8000_0000_0000_0003,
             64'h7FFF_FFFF_FFFF_FFFD, 64'd6, 1'b1, 1'b0, 1'b0);
    directed("sub_small", 2'b01, 64'hFFFF_FFFF_FFFF_FFFB, 64'd107,
             64'hFFFF_FFFF_FFFF_FF90, 1'b0, 1'b0, 1'b1);
    directed("add_small", 2'b00, 64'hFFFF_FFFF_FFFF_FFFB, 64'd107,
             64'd102, 1'b0, 1'b0, 1'b0);
    directed("add_max_plus_one", 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
             64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
    directed("and_mask", 2'b10, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1'b0, 1'b0);
    directed("xor_equal", 2'b11, 64'hDEAD_BEEF_1234_5678,
             64'hDEAD_BEEF_1234_5678, 64'd0, 1'b0, 1'b1, 1'b0);
    directed("add_neg_overflow", 2'b00, 64'h8000_0000_0000_0000,
             64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    directed("xor_sign", 2'b11, 64'h8000_0000_0000_00FF, 64'h0000_0000_0000_000F,
             64'h8000_0000_0000_00F0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic, one new operation per cycle, with a mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      drive_random();
      if (i == 200) begin
        #2 rst = 1'b1;
        #1 check_reset_values("reset_midstream");
        $display("reset asserted mid-cycle at %0t", $time);
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          drive_random();
        end
        #2 rst = 1'b0;
        $display("reset released mid-cycle at %0t", $time);
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
